// File: rtl/frame_dbuf_ctrl_if.sv
// rtl/frame_dbuf_ctrl_if.sv - pixel write stream and display raster bus of the ping-pong frame store
//
// Purpose: groups the write handshake, the display strobe and the scan-out outputs of
// frame_dbuf_ctrl so loader, pixel pipe and controller share one bundle.
// Signals:
//   pix_clk_en    strobe from the display side: advance the raster one pixel
//   wr_valid      wr_data holds a source pixel
//   wr_data       source pixel, raster order
//   wr_ready      back bank accepts a pixel this cycle
//   pix_x, pix_y  current display position
//   pix_valid     pix_data valid (one cycle after each pix_clk_en)
//   pix_data      pixel for the position sampled at the previous strobe
//   swap_pulse    one-cycle pulse when the banks swap
//   frame_repeat  saturating count of re-displayed frames
// Modports: master = loader/display side, slave = frame_dbuf_ctrl.

interface frame_dbuf_ctrl_if #(
    parameter int SRC_W = 200,
    parameter int SRC_H = 150,
    parameter int SCALE = 4,
    parameter int PIX_W = 1,
    parameter int RPT_W = 8
);
    localparam int DISP_W = SRC_W * SCALE;
    localparam int DISP_H = SRC_H * SCALE;
    localparam int X_W    = (DISP_W > 1) ? $clog2(DISP_W) : 1;
    localparam int Y_W    = (DISP_H > 1) ? $clog2(DISP_H) : 1;

    logic             pix_clk_en;
    logic             wr_valid;
    logic [PIX_W-1:0] wr_data;
    logic             wr_ready;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             swap_pulse;
    logic [RPT_W-1:0] frame_repeat;

    modport master (
        output pix_clk_en, wr_valid, wr_data,
        input  wr_ready, pix_x, pix_y, pix_valid, pix_data, swap_pulse, frame_repeat
    );

    modport slave (
        input  pix_clk_en, wr_valid, wr_data,
        output wr_ready, pix_x, pix_y, pix_valid, pix_data, swap_pulse, frame_repeat
    );
endinterface

// File: rtl/frame_dbuf_ctrl.sv
// rtl/frame_dbuf_ctrl.sv - ping-pong frame store between the SPI frame loader and the VGA pixel pipe
//
// Purpose: two SRC_W x SRC_H banks of PIX_W-bit pixels. The loader fills the back bank
// through a valid/ready stream while the front bank is scanned out with integer
// upscaling by SCALE. Banks swap only at the display frame boundary and only when the
// back frame is complete; otherwise the front frame repeats and frame_repeat counts it.
// Ports:
//   CLK_40  system clock
//   reset   synchronous, active-high
//   bus     frame_dbuf_ctrl_if.slave (write stream in, raster strobe in, scan-out out)

module frame_dbuf_ctrl #(
    parameter int SRC_W = 200,
    parameter int SRC_H = 150,
    parameter int SCALE = 4,
    parameter int PIX_W = 1,
    parameter int RPT_W = 8
) (
    input  logic                  CLK_40,
    input  logic                  reset,
    frame_dbuf_ctrl_if.slave      bus
);
    localparam int DEPTH  = SRC_W * SRC_H;
    localparam int DISP_W = SRC_W * SCALE;
    localparam int DISP_H = SRC_H * SCALE;
    localparam int X_W    = (DISP_W > 1) ? $clog2(DISP_W) : 1;
    localparam int Y_W    = (DISP_H > 1) ? $clog2(DISP_H) : 1;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SX_W   = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int SUB_W  = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [X_W-1:0]   X_LAST   = X_W'(DISP_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(DISP_H - 1);
    localparam logic [AW-1:0]    PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0]    ROW_STEP = AW'(SRC_W);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
    localparam logic [RPT_W-1:0] RPT_MAX  = {RPT_W{1'b1}};

    typedef enum logic {
        WR_FILL,
        WR_PEND
    } wr_state_t;

    wr_state_t wr_state, wr_state_nxt;

    // Pixel storage, synchronous read
    logic [PIX_W-1:0] mem0 [DEPTH];
    logic [PIX_W-1:0] mem1 [DEPTH];
    logic [PIX_W-1:0] rd0, rd1;

    logic             front;      // bank being displayed; back bank is ~front
    logic             shown;      // a completed frame has been swapped in since reset
    logic [AW-1:0]    wr_ptr;

    // Raster: display position plus source-space position derived without dividers
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;
    logic [SUB_W-1:0] sub_x, sub_y;
    logic [SX_W-1:0]  src_x;
    logic [AW-1:0]    row_base;   // src_y * SRC_W, stepped by SRC_W once per SCALE display rows
    logic [AW-1:0]    rd_addr;

    // Read-side pipeline: bank and visibility captured with the read itself
    logic             rd_sel;
    logic             rd_show;
    logic             pix_valid;
    logic             swap_pulse;
    logic [RPT_W-1:0] frame_repeat;

    logic wr_ready, wr_fire, wr_last;
    logic x_last, y_last, boundary, back_ready, do_swap;

    assign wr_ready   = (wr_state == WR_FILL);
    assign wr_fire    = bus.wr_valid && wr_ready;
    assign wr_last    = wr_fire && (wr_ptr == PTR_LAST);
    assign x_last     = (pix_x == X_LAST);
    assign y_last     = (pix_y == Y_LAST);
    assign boundary   = bus.pix_clk_en && x_last && y_last;
    // A frame whose last pixel arrives on the boundary cycle still counts as ready
    assign back_ready = (wr_state == WR_PEND) || wr_last;
    assign do_swap    = boundary && back_ready;
    assign rd_addr    = row_base + AW'(src_x);

    // Write FSM
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            wr_state <= WR_FILL;
        end else begin
            wr_state <= wr_state_nxt;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            WR_FILL: begin
                if (do_swap) begin
                    wr_state_nxt = WR_FILL;
                end else if (wr_last) begin
                    wr_state_nxt = WR_PEND;
                end
            end
            WR_PEND: begin
                if (do_swap) begin
                    wr_state_nxt = WR_FILL;
                end
            end
            default: wr_state_nxt = WR_FILL;
        endcase
    end

    // Memory: writes go to the back bank, reads are issued from both and selected later
    always_ff @(posedge CLK_40) begin
        if (wr_fire && !reset) begin
            if (front) begin
                mem0[wr_ptr] <= bus.wr_data;
            end else begin
                mem1[wr_ptr] <= bus.wr_data;
            end
        end
        if (bus.pix_clk_en) begin
            rd0 <= mem0[rd_addr];
            rd1 <= mem1[rd_addr];
        end
    end

    // Control, pointer, bank selection and status
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            wr_ptr       <= '0;
            front        <= 1'b0;
            shown        <= 1'b0;
            rd_sel       <= 1'b0;
            rd_show      <= 1'b0;
            pix_valid    <= 1'b0;
            swap_pulse   <= 1'b0;
            frame_repeat <= '0;
        end else begin
            pix_valid  <= bus.pix_clk_en;
            swap_pulse <= do_swap;

            if (wr_fire) begin
                wr_ptr <= wr_last ? '0 : wr_ptr + AW'(1);
            end

            // The boundary read sees the old front bank; the swap applies from the next strobe
            if (bus.pix_clk_en) begin
                rd_sel  <= front;
                rd_show <= shown;
            end

            if (do_swap) begin
                front <= ~front;
                shown <= 1'b1;
            end else if (boundary && (frame_repeat != RPT_MAX)) begin
                frame_repeat <= frame_repeat + RPT_W'(1);
            end
        end
    end

    // Raster counters
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            pix_x    <= '0;
            pix_y    <= '0;
            sub_x    <= '0;
            sub_y    <= '0;
            src_x    <= '0;
            row_base <= '0;
        end else if (bus.pix_clk_en) begin
            if (x_last) begin
                pix_x <= '0;
                sub_x <= '0;
                src_x <= '0;
                if (y_last) begin
                    pix_y    <= '0;
                    sub_y    <= '0;
                    row_base <= '0;
                end else begin
                    pix_y <= pix_y + Y_W'(1);
                    if (sub_y == SUB_LAST) begin
                        sub_y    <= '0;
                        row_base <= row_base + ROW_STEP;
                    end else begin
                        sub_y <= sub_y + SUB_W'(1);
                    end
                end
            end else begin
                pix_x <= pix_x + X_W'(1);
                if (sub_x == SUB_LAST) begin
                    sub_x <= '0;
                    src_x <= src_x + SX_W'(1);
                end else begin
                    sub_x <= sub_x + SUB_W'(1);
                end
            end
        end
    end

    assign bus.wr_ready     = wr_ready;
    assign bus.pix_x        = pix_x;
    assign bus.pix_y        = pix_y;
    assign bus.pix_valid    = pix_valid;
    assign bus.pix_data     = rd_show ? (rd_sel ? rd1 : rd0) : '0;
    assign bus.swap_pulse   = swap_pulse;
    assign bus.frame_repeat = frame_repeat;

endmodule

// File: tb/tb_frame_dbuf_ctrl.sv
// tb/tb_frame_dbuf_ctrl.sv - randomized self-checking bench for frame_dbuf_ctrl

module tb_frame_dbuf_ctrl;
    localparam int SRC_W  = 4;
    localparam int SRC_H  = 3;
    localparam int SCALE  = 2;
    localparam int PIX_W  = 2;
    localparam int RPT_W  = 8;
    localparam int N      = SRC_W * SRC_H;
    localparam int DW     = SRC_W * SCALE;
    localparam int DH     = SRC_H * SCALE;
    localparam int FRAME  = DW * DH;
    localparam int RPT_MX = (1 << RPT_W) - 1;

    logic CLK_40 = 1'b0;
    logic reset  = 1'b1;

    always #5 CLK_40 = ~CLK_40;

    frame_dbuf_ctrl_if #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .PIX_W(PIX_W), .RPT_W(RPT_W)
    ) bus ();

    frame_dbuf_ctrl #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .PIX_W(PIX_W), .RPT_W(RPT_W)
    ) dut (
        .CLK_40 (CLK_40),
        .reset  (reset),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: two banks as plain arrays, frame-level bookkeeping
    int m_mem [2][N];
    int m_front, m_cnt, m_x, m_y, m_rep;
    bit m_full, m_shown;

    // Observations from the most recent step
    bit last_swap, last_acc;
    int last_sx, last_sy;
    int n_swaps;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_front = 0;
        m_cnt   = 0;
        m_x     = 0;
        m_y     = 0;
        m_rep   = 0;
        m_full  = 0;
        m_shown = 0;
    endtask

    // Called at a falling edge; drives one cycle and checks its results at the next falling edge
    task automatic step(input bit strobe, input bit wv, input int wd);
        bit acc, bnd, swp;
        int e_data;
        logic [PIX_W-1:0] d;
        d = wd[PIX_W-1:0];
        bus.pix_clk_en = strobe;
        bus.wr_valid   = wv;
        bus.wr_data    = d;
        check_val("wr_ready", bus.wr_ready, !m_full);

        acc    = wv && !m_full;
        bnd    = strobe && (m_x == DW-1) && (m_y == DH-1);
        e_data = 0;
        if (strobe && m_shown)
            e_data = m_mem[m_front][(m_y / SCALE) * SRC_W + (m_x / SCALE)];
        last_sx = m_x;
        last_sy = m_y;
        if (acc) begin
            m_mem[1 - m_front][m_cnt] = int'(d);
            m_cnt++;
            if (m_cnt == N) begin
                m_full = 1;
                m_cnt  = 0;
            end
        end
        swp = bnd && m_full;
        if (swp) begin
            m_front = 1 - m_front;
            m_full  = 0;
            m_shown = 1;
        end else if (bnd && m_rep < RPT_MX) begin
            m_rep++;
        end
        if (strobe) begin
            if (m_x == DW-1) begin
                m_x = 0;
                m_y = (m_y == DH-1) ? 0 : m_y + 1;
            end else begin
                m_x++;
            end
        end

        @(posedge CLK_40);
        @(negedge CLK_40);
        check_val("pix_valid", bus.pix_valid, strobe);
        if (strobe) check_val("pix_data", bus.pix_data, e_data);
        check_val("swap_pulse", bus.swap_pulse, swp);
        check_val("frame_repeat", bus.frame_repeat, m_rep);
        check_val("pix_x", bus.pix_x, m_x);
        check_val("pix_y", bus.pix_y, m_y);
        last_swap = swp;
        last_acc  = acc;
        if (swp) n_swaps++;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.pix_clk_en = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        @(posedge CLK_40);
        @(negedge CLK_40);
        reset = 1'b0;
        model_reset();
        check_val("rst_wr_ready", bus.wr_ready, 1);
        check_val("rst_pix_x", bus.pix_x, 0);
        check_val("rst_pix_y", bus.pix_y, 0);
        check_val("rst_pix_valid", bus.pix_valid, 0);
        check_val("rst_pix_data", bus.pix_data, 0);
        check_val("rst_swap_pulse", bus.swap_pulse, 0);
        check_val("rst_frame_repeat", bus.frame_repeat, 0);
    endtask

    initial begin
        int cur, swaps0;
        bit seen;
        bus.pix_clk_en = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        n_swaps        = 0;
        do_reset();

        // 1: no writes, one full frame of strobes -> black, one repeat, no swap
        for (int i = 0; i < FRAME; i++) step(1, 0, 0);
        check_val("s1_repeat", bus.frame_repeat, 1);
        check_val("s1_swaps", n_swaps, 0);

        // 2: load addr%4, display one frame to swap, then check the new frame
        for (int i = 0; i < N; i++) step(0, 1, i % 4);
        for (int i = 0; i < FRAME; i++) step(1, 0, 0);
        check_val("s2_swaps", n_swaps, 1);
        for (int i = 0; i < FRAME; i++) begin
            step(1, 0, 0);
            if (last_sx == 5 && last_sy == 3) check_val("s2_pix_5_3", bus.pix_data, 2);
        end

        // 3: full back bank, wr_valid held high with the same data until a swap
        for (int i = 0; i < N; i++) step(0, 1, $urandom_range(0, 3));
        cur  = $urandom_range(0, 3);
        seen = 0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            step(1, 1, cur);
            check_val("s3_no_accept", last_acc, 0);
            seen = last_swap;
        end
        check_val("s3_swap_seen", seen, 1);
        check_val("s3_ready_after_swap", bus.wr_ready, 1);
        step(1, 1, cur);
        check_val("s3_first_accept", last_acc, 1);
        for (int i = 1; i < N; i++) step(1, 1, $urandom_range(0, 3));
        for (int i = 0; i < 2 * FRAME; i++) step(1, 0, 0);

        // 4: last write accepted on the boundary strobe
        do_reset();
        for (int i = 0; i < FRAME - 1; i++) step(1, 0, 0);
        for (int i = 0; i < N - 1; i++) step(0, 1, $urandom_range(0, 3));
        step(1, 1, $urandom_range(0, 3));
        check_val("s4_swap", last_swap, 1);
        check_val("s4_repeat", bus.frame_repeat, 0);
        for (int i = 0; i < FRAME; i++) step(1, 0, 0);

        // 5: 300 frames with no writes -> saturation
        for (int i = 0; i < 300 * FRAME; i++) step(1, 0, 0);
        check_val("s5_repeat_sat", bus.frame_repeat, RPT_MX);

        // 6: reset after a partial frame and mid-raster, then a fresh frame
        do_reset();
        for (int i = 0; i < 7; i++) step(1, 1, 3);
        for (int i = 0; i < 20; i++) step(1, 0, 0);
        do_reset();
        swaps0 = n_swaps;
        for (int i = 0; i < N; i++) step(0, 1, $urandom_range(0, 2));
        for (int i = 0; i < 2 * FRAME; i++) step(1, 0, 0);
        check_val("s6_one_swap", n_swaps - swaps0, 1);

        // Random traffic: mixed strobes and writes, occasional reset
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
